// File: rtl/range_arbiter.sv
// Round-robin arbiter sharing one RangeFinder datapath between two sample streams.
// Optional in-burst gap timeout is enabled by defining RANGE_ARB_TIMEOUT_EN.

module range_arbiter #(
    parameter int WIDTH      = 10,
    parameter int RESULT_LAT = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       ch_req,
    input  logic [1:0]       ch_valid,
    input  logic [1:0]       ch_last,
    input  logic [WIDTH-1:0] ch0_data,
    input  logic [WIDTH-1:0] ch1_data,
    output logic [1:0]       grant,
    output logic [WIDTH-1:0] rf_data_in,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_debug_error,
    output logic [WIDTH-1:0] result,
    output logic             result_ch,
    output logic             result_err,
    output logic             result_valid
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        REPORT
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RESULT_LAT - 1);

    if (RESULT_LAT < 1 || RESULT_LAT > 3 || TIMEOUT < 1) begin : g_param_check
        $error("range_arbiter: RESULT_LAT must be 1..3 and TIMEOUT at least 1");
    end

    state_t           state;
    state_t           state_d;
    logic             ptr;
    logic             owner;
    logic             first_q;
    logic             err_q;
    logic [1:0]       lat_cnt;
    logic [WIDTH-1:0] held_q;
    logic             sel;
    logic             accept;
    logic             force_end;
    logic             timeout_hit;
    logic [WIDTH-1:0] sample;

    // The pointer channel wins a tie; otherwise whichever channel is requesting.
    assign sel    = ch_req[ptr] ? ptr : ~ptr;
    assign sample = owner ? ch1_data : ch0_data;

`ifdef RANGE_ARB_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clock) begin
        if (reset || state != STREAM || accept) begin
            gap_cnt <= '0;
        end else if (!timeout_hit) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    assign timeout_hit = (gap_cnt == GAP_W'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state;
        accept       = 1'b0;
        force_end    = 1'b0;
        rf_go        = 1'b0;
        rf_finish    = 1'b0;
        result_valid = 1'b0;
        rf_data_in   = held_q;
        case (state)
            IDLE: begin
                if (|ch_req) state_d = STREAM;
            end
            STREAM: begin
                accept = grant[owner] & ch_valid[owner];
                // An accepted last sample ends the burst cleanly even if the request drops with it.
                force_end = !(accept && ch_last[owner]) && (!ch_req[owner] || timeout_hit);
                if (accept) rf_data_in = sample;
                rf_go     = accept & first_q;
                rf_finish = (accept & ch_last[owner]) | force_end;
                if (rf_finish) state_d = DRAIN;
            end
            DRAIN: begin
                if (lat_cnt == LAT_LAST) state_d = REPORT;
            end
            REPORT: begin
                result_valid = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            first_q    <= 1'b1;
            err_q      <= 1'b0;
            lat_cnt    <= '0;
            held_q     <= '0;
            result     <= '0;
            result_ch  <= 1'b0;
            result_err <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (|ch_req) begin
                        owner   <= sel;
                        grant   <= sel ? 2'b10 : 2'b01;
                        first_q <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        held_q  <= sample;
                        first_q <= 1'b0;
                    end
                    if (rf_finish) begin
                        grant   <= '0;
                        lat_cnt <= '0;
                        err_q   <= force_end;
                    end
                end
                DRAIN: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (state_d == REPORT) begin
                        result     <= rf_range;
                        result_ch  <= owner;
                        result_err <= rf_debug_error | err_q;
                    end
                end
                REPORT: begin
                    ptr <= ~owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_range_arbiter.sv
// Directed self-checking bench for range_arbiter with a behavioural RangeFinder model.
// Build with RANGE_ARB_TIMEOUT_EN defined to exercise the gap timeout path.

module tb_range_arbiter;

    localparam int WIDTH = 10;

    logic             clock;
    logic             reset;
    logic [1:0]       ch_req;
    logic [1:0]       ch_valid;
    logic [1:0]       ch_last;
    logic [WIDTH-1:0] ch0_data;
    logic [WIDTH-1:0] ch1_data;
    logic [1:0]       grant;
    logic [WIDTH-1:0] rf_data_in;
    logic             rf_go;
    logic             rf_finish;
    logic [WIDTH-1:0] rf_range;
    logic             rf_debug_error;
    logic [WIDTH-1:0] result;
    logic             result_ch;
    logic             result_err;
    logic             result_valid;
    logic             tb_dbg_err;

    int checks;
    int errors;

    range_arbiter #(.WIDTH(WIDTH), .RESULT_LAT(1), .TIMEOUT(255)) dut (
        .clock(clock), .reset(reset), .ch_req(ch_req), .ch_valid(ch_valid), .ch_last(ch_last),
        .ch0_data(ch0_data), .ch1_data(ch1_data), .grant(grant), .rf_data_in(rf_data_in),
        .rf_go(rf_go), .rf_finish(rf_finish), .rf_range(rf_range), .rf_debug_error(rf_debug_error),
        .result(result), .result_ch(result_ch), .result_err(result_err), .result_valid(result_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RangeFinder model: range is valid only in the single cycle after finish, 3FF otherwise.
    logic [WIDTH-1:0] mdl_min, mdl_max, mdl_rng, cur_lo, cur_hi;
    logic             mdl_rdy;

    always_comb begin
        cur_lo = rf_go ? rf_data_in : ((rf_data_in < mdl_min) ? rf_data_in : mdl_min);
        cur_hi = rf_go ? rf_data_in : ((rf_data_in > mdl_max) ? rf_data_in : mdl_max);
    end

    always @(posedge clock) begin
        if (reset) begin
            mdl_min <= '0;
            mdl_max <= '0;
            mdl_rng <= '0;
            mdl_rdy <= 1'b0;
        end else begin
            mdl_min <= cur_lo;
            mdl_max <= cur_hi;
            mdl_rdy <= rf_finish;
            if (rf_finish) mdl_rng <= cur_hi - cur_lo;
        end
    end

    assign rf_range       = mdl_rdy ? mdl_rng : 10'h3FF;
    assign rf_debug_error = mdl_rdy & tb_dbg_err;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] valid, input logic [1:0] last,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        ch_req   = req;
        ch_valid = valid;
        ch_last  = last;
        ch0_data = d0;
        ch1_data = d1;
    endtask

    task automatic test_reset();
        tick(); tick(); #4;
        checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (rf_go !== 1'b0) begin errors++; $display("[TB] FAIL reset_go: got %b expected 0", rf_go); end
        checks++; if (rf_finish !== 1'b0) begin errors++; $display("[TB] FAIL reset_finish: got %b expected 0", rf_finish); end
        checks++; if (rf_data_in !== 10'd0) begin errors++; $display("[TB] FAIL reset_data_in: got %0d expected 0", rf_data_in); end
        checks++; if (result !== 10'd0) begin errors++; $display("[TB] FAIL reset_result: got %0d expected 0", result); end
        checks++; if (result_ch !== 1'b0 || result_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_result_tags: got ch=%b err=%b expected 0 0", result_ch, result_err); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_result_valid: got %b expected 0", result_valid); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        tick(); drive(2'b01, 2'b01, 2'b00, 10'd5, 10'd0); #4;
        checks++; if (rf_go !== 1'b0 || grant !== 2'b00) begin errors++; $display("[TB] FAIL basic_pre_grant: got go=%b grant=%b expected 0 00", rf_go, grant); end
        tick(); #4;
        checks++; if (grant !== 2'b01) begin errors++; $display("[TB] FAIL basic_grant: got %b expected 01", grant); end
        checks++; if (rf_go !== 1'b1 || rf_finish !== 1'b0 || rf_data_in !== 10'd5) begin errors++; $display("[TB] FAIL basic_first: got go=%b fin=%b data=%0d expected 1 0 5", rf_go, rf_finish, rf_data_in); end
        tick(); drive(2'b01, 2'b01, 2'b00, 10'd20, 10'd0); #4;
        checks++; if (rf_go !== 1'b0 || rf_data_in !== 10'd20) begin errors++; $display("[TB] FAIL basic_mid: got go=%b data=%0d expected 0 20", rf_go, rf_data_in); end
        tick(); drive(2'b01, 2'b01, 2'b01, 10'd3, 10'd0); #4;
        checks++; if (rf_finish !== 1'b1 || rf_data_in !== 10'd3) begin errors++; $display("[TB] FAIL basic_last: got fin=%b data=%0d expected 1 3", rf_finish, rf_data_in); end
        tick(); drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        checks++; if (grant !== 2'b00 || result_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain: got grant=%b rv=%b expected 00 0", grant, result_valid); end
        tick(); #4;
        checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_result_valid: got %b expected 1", result_valid); end
        checks++; if (result !== 10'd17 || result_ch !== 1'b0 || result_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_result: got %0d ch=%b err=%b expected 17 0 0", result, result_ch, result_err); end
        tick(); #4;
        checks++; if (result_valid !== 1'b0 || result !== 10'd17) begin errors++; $display("[TB] FAIL basic_hold: got rv=%b result=%0d expected 0 17", result_valid, result); end
    endtask

    task automatic test_round_robin();
        tick(); reset = 1'b1; drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0);
        tick(); reset = 1'b0; drive(2'b11, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); drive(2'b11, 2'b11, 2'b11, 10'd8, 10'd50); #4;
        checks++; if (grant !== 2'b01) begin errors++; $display("[TB] FAIL rr_first_grant: got %b expected 01", grant); end
        checks++; if (rf_go !== 1'b1 || rf_finish !== 1'b1 || rf_data_in !== 10'd8) begin errors++; $display("[TB] FAIL rr_ch0_burst: got go=%b fin=%b data=%0d expected 1 1 8", rf_go, rf_finish, rf_data_in); end
        tick(); drive(2'b11, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); #4;
        checks++; if (result_valid !== 1'b1 || result_ch !== 1'b0 || result !== 10'd0) begin errors++; $display("[TB] FAIL rr_result0: got rv=%b ch=%b result=%0d expected 1 0 0", result_valid, result_ch, result); end
        tick(); #4;
        checks++; if (grant !== 2'b00 || rf_go !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle_gap: got grant=%b go=%b expected 00 0", grant, rf_go); end
        tick(); drive(2'b11, 2'b11, 2'b11, 10'd99, 10'd30); #4;
        checks++; if (grant !== 2'b10) begin errors++; $display("[TB] FAIL rr_second_grant: got %b expected 10", grant); end
        checks++; if (rf_data_in !== 10'd30 || rf_go !== 1'b1 || rf_finish !== 1'b1) begin errors++; $display("[TB] FAIL rr_ch1_burst: got data=%0d go=%b fin=%b expected 30 1 1", rf_data_in, rf_go, rf_finish); end
        tick(); drive(2'b11, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); #4;
        checks++; if (result_valid !== 1'b1 || result_ch !== 1'b1) begin errors++; $display("[TB] FAIL rr_result1: got rv=%b ch=%b expected 1 1", result_valid, result_ch); end
        tick(); #4;
        tick(); tb_dbg_err = 1'b1; drive(2'b11, 2'b01, 2'b01, 10'd1, 10'd0); #4;
        checks++; if (grant !== 2'b01 || rf_finish !== 1'b1) begin errors++; $display("[TB] FAIL rr_third_grant: got grant=%b fin=%b expected 01 1", grant, rf_finish); end
        tick(); drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); #4;
        checks++; if (result_valid !== 1'b1 || result_err !== 1'b1 || result_ch !== 1'b0) begin errors++; $display("[TB] FAIL rr_debug_error: got rv=%b err=%b ch=%b expected 1 1 0", result_valid, result_err, result_ch); end
        tick(); tb_dbg_err = 1'b0; #4;
    endtask

    task automatic test_gaps();
        tick(); drive(2'b10, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); drive(2'b10, 2'b10, 2'b00, 10'd0, 10'd100); #4;
        checks++; if (grant !== 2'b10 || rf_go !== 1'b1 || rf_data_in !== 10'd100) begin errors++; $display("[TB] FAIL gaps_first: got grant=%b go=%b data=%0d expected 10 1 100", grant, rf_go, rf_data_in); end
        tick(); drive(2'b10, 2'b00, 2'b00, 10'd0, 10'd55); #4;
        checks++; if (rf_data_in !== 10'd100 || rf_go !== 1'b0 || rf_finish !== 1'b0) begin errors++; $display("[TB] FAIL gaps_hold1: got data=%0d go=%b fin=%b expected 100 0 0", rf_data_in, rf_go, rf_finish); end
        tick(); #4;
        checks++; if (rf_data_in !== 10'd100) begin errors++; $display("[TB] FAIL gaps_hold2: got %0d expected 100", rf_data_in); end
        tick(); drive(2'b10, 2'b10, 2'b10, 10'd0, 10'd40); #4;
        checks++; if (rf_finish !== 1'b1 || rf_data_in !== 10'd40) begin errors++; $display("[TB] FAIL gaps_last: got fin=%b data=%0d expected 1 40", rf_finish, rf_data_in); end
        tick(); drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); #4;
        checks++; if (result_valid !== 1'b1 || result !== 10'd60 || result_ch !== 1'b1 || result_err !== 1'b0) begin errors++; $display("[TB] FAIL gaps_result: got rv=%b result=%0d ch=%b err=%b expected 1 60 1 0", result_valid, result, result_ch, result_err); end
        tick(); #4;
    endtask

    task automatic test_single_sample();
        tick(); drive(2'b01, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); drive(2'b01, 2'b01, 2'b01, 10'd7, 10'd0); #4;
        checks++; if (rf_go !== 1'b1 || rf_finish !== 1'b1 || rf_data_in !== 10'd7) begin errors++; $display("[TB] FAIL single_go_finish: got go=%b fin=%b data=%0d expected 1 1 7", rf_go, rf_finish, rf_data_in); end
        tick(); drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); #4;
        checks++; if (result_valid !== 1'b1 || result !== 10'd0 || result_ch !== 1'b0 || result_err !== 1'b0) begin errors++; $display("[TB] FAIL single_result: got rv=%b result=%0d ch=%b err=%b expected 1 0 0 0", result_valid, result, result_ch, result_err); end
        tick(); #4;
    endtask

    task automatic test_timeout();
        logic seen;
        int   gaps;
        seen = 1'b0;
        gaps = 0;
        tick(); drive(2'b10, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); drive(2'b10, 2'b10, 2'b00, 10'd0, 10'd50); #4;
        checks++; if (rf_go !== 1'b1) begin errors++; $display("[TB] FAIL stall_first: got go=%b expected 1", rf_go); end
        drive(2'b10, 2'b00, 2'b00, 10'd0, 10'd0);
        for (int i = 0; i < 300 && !seen; i++) begin
            tick(); #4;
            if (rf_finish === 1'b1) seen = 1'b1;
            else gaps++;
        end
`ifdef RANGE_ARB_TIMEOUT_EN
        checks++; if (seen !== 1'b1 || gaps != 255) begin errors++; $display("[TB] FAIL timeout_finish: got seen=%b gaps=%0d expected 1 255", seen, gaps); end
        tick(); drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); #4;
        checks++; if (result_valid !== 1'b1 || result_err !== 1'b1 || result_ch !== 1'b1 || result !== 10'd0) begin errors++; $display("[TB] FAIL timeout_result: got rv=%b err=%b ch=%b result=%0d expected 1 1 1 0", result_valid, result_err, result_ch, result); end
`else
        checks++; if (seen !== 1'b0 || grant !== 2'b10) begin errors++; $display("[TB] FAIL stall_hold: got finish_seen=%b grant=%b expected 0 10", seen, grant); end
        tick(); drive(2'b10, 2'b10, 2'b10, 10'd0, 10'd50); #4;
        checks++; if (rf_finish !== 1'b1) begin errors++; $display("[TB] FAIL stall_last: got fin=%b expected 1", rf_finish); end
        tick(); drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); #4;
        checks++; if (result_valid !== 1'b1 || result_err !== 1'b0 || result !== 10'd0) begin errors++; $display("[TB] FAIL stall_result: got rv=%b err=%b result=%0d expected 1 0 0", result_valid, result_err, result); end
`endif
        tick(); #4;
    endtask

    task automatic test_early_drop();
        tick(); drive(2'b01, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); drive(2'b01, 2'b01, 2'b00, 10'd9, 10'd0); #4;
        checks++; if (rf_go !== 1'b1 || rf_data_in !== 10'd9) begin errors++; $display("[TB] FAIL drop_first: got go=%b data=%0d expected 1 9", rf_go, rf_data_in); end
        tick(); drive(2'b01, 2'b01, 2'b00, 10'd2, 10'd0); #4;
        checks++; if (rf_finish !== 1'b0) begin errors++; $display("[TB] FAIL drop_no_early_finish: got %b expected 0", rf_finish); end
        tick(); drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        checks++; if (rf_finish !== 1'b1 || rf_data_in !== 10'd2 || rf_go !== 1'b0) begin errors++; $display("[TB] FAIL drop_forced_finish: got fin=%b data=%0d go=%b expected 1 2 0", rf_finish, rf_data_in, rf_go); end
        tick(); #4;
        checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL drop_grant_release: got %b expected 00", grant); end
        tick(); #4;
        checks++; if (result_valid !== 1'b1 || result !== 10'd7 || result_err !== 1'b1 || result_ch !== 1'b0) begin errors++; $display("[TB] FAIL drop_result: got rv=%b result=%0d err=%b ch=%b expected 1 7 1 0", result_valid, result, result_err, result_ch); end
        tick(); #4;
    endtask

    task automatic test_reset_mid_burst();
        logic rv_seen;
        rv_seen = 1'b0;
        tick(); drive(2'b10, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); drive(2'b10, 2'b10, 2'b00, 10'd0, 10'd10); #4;
        checks++; if (rf_go !== 1'b1 || grant !== 2'b10) begin errors++; $display("[TB] FAIL midrst_start: got go=%b grant=%b expected 1 10", rf_go, grant); end
        tick(); drive(2'b10, 2'b10, 2'b00, 10'd0, 10'd20); reset = 1'b1; #4;
        tick(); #4;
        checks++; if (grant !== 2'b00 || rf_go !== 1'b0 || rf_finish !== 1'b0 || rf_data_in !== 10'd0) begin errors++; $display("[TB] FAIL midrst_outputs: got grant=%b go=%b fin=%b data=%0d expected 00 0 0 0", grant, rf_go, rf_finish, rf_data_in); end
        checks++; if (result !== 10'd0 || result_err !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_result: got result=%0d err=%b rv=%b expected 0 0 0", result, result_err, result_valid); end
        tick(); reset = 1'b0; drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        for (int i = 0; i < 4; i++) begin
            if (result_valid === 1'b1) rv_seen = 1'b1;
            tick(); #4;
        end
        checks++; if (rv_seen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_result: got result_valid=1 expected 0"); end
        drive(2'b11, 2'b00, 2'b00, 10'd0, 10'd0);
        tick(); drive(2'b11, 2'b01, 2'b01, 10'd1, 10'd0); #4;
        checks++; if (grant !== 2'b01) begin errors++; $display("[TB] FAIL midrst_ptr: got grant=%b expected 01", grant); end
        tick(); drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0); #4;
        tick(); #4;
        tick(); #4;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        tb_dbg_err = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0);
        test_reset();
        test_basic();
        test_round_robin();
        test_gaps();
        test_single_sample();
        test_timeout();
        test_early_drop();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000ns expected earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/range_arbiter.md
Name: range_arbiter

Overview:
Shares one RangeFinder datapath (10-bit data_in, go, finish, range, debug_error) between two sample-stream requesters. Grants the datapath to one channel per burst using round-robin, and converts that channel's valid/last stream into the go/finish sequence. After each burst it captures range and debug_error and presents them as a tagged result. Sits between the chip-level I/O and the RangeFinder instance in my_chip.

Parameters:
WIDTH, 10, sample and range width; must match the RangeFinder instance
RESULT_LAT, 1, cycles from the rf_finish cycle to the cycle rf_range/rf_debug_error are sampled (1..3)
TIMEOUT, 255, idle-cycle limit inside a burst; used only with RANGE_ARB_TIMEOUT_EN

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ch_req  in  2  per-channel burst request; held high until that channel's last sample is accepted
ch_valid  in  2  per-channel sample valid
ch_last  in  2  marks final sample of burst; meaningful only with ch_valid
ch0_data  in  WIDTH  channel 0 sample
ch1_data  in  WIDTH  channel 1 sample
grant  out  2  one-hot owner; a sample is accepted when grant[i] & ch_valid[i]
rf_data_in  out  WIDTH  to RangeFinder data_in
rf_go  out  1  to RangeFinder go
rf_finish  out  1  to RangeFinder finish
rf_range  in  WIDTH  from RangeFinder range
rf_debug_error  in  1  from RangeFinder debug_error
result  out  WIDTH  captured range
result_ch  out  1  channel that produced result
result_err  out  1  captured error (rf_debug_error | arbiter error)
result_valid  out  1  one-cycle pulse when result/result_ch/result_err update

Behaviour:
- Reset: grant=0, rf_go=0, rf_finish=0, rf_data_in=0, result=0, result_ch=0, result_err=0, result_valid=0, RR pointer=ch0, state=IDLE. Reset mid-burst abandons the burst; no result is issued.
- States: IDLE, STREAM, DRAIN, REPORT.
- IDLE: if any ch_req, pick a channel (ptr channel first, else the other). Register grant next cycle -> STREAM. If there is no request, stay in IDLE.
- STREAM: first accepted sample -> rf_go=1, rf_data_in=sample in the same cycle (combinational from the mux, registered policy is free). Later accepted samples pass through with rf_go=0.
- Gap cycles (no valid): hold rf_data_in at the last accepted sample with go/finish low. Repeating a sample does not alter min/max.
- Accepted sample with ch_last: rf_finish=1 that cycle and grant drops the next cycle -> DRAIN.
- First sample also last: rf_go and rf_finish are both high in one cycle (single-sample burst, range 0).
- DRAIN: wait RESULT_LAT cycles after the finish cycle, then sample rf_range and rf_debug_error -> REPORT.
- REPORT: result_valid=1 for exactly one cycle. The RR pointer moves to the other channel -> IDLE. A new grant is issued no earlier than the cycle after REPORT (min 2 idle cycles between bursts on rf_go).
- Non-granted channel: its ch_valid is ignored; no sample is accepted, and it keeps its request pending.
- ch_req of the owner dropping before last: force rf_finish=1 with the held sample and set result_err=1.
- Outputs result, result_ch and result_err hold their values until the next result_valid.
- No arithmetic is done in the arbiter; range width is passed through unchanged.

Optional Feature:
RANGE_ARB_TIMEOUT_EN defined: a counter in STREAM counts consecutive gap cycles and resets on each accepted sample. When it reaches TIMEOUT, the arbiter forces rf_finish, the burst ends as for early request drop, and result_err=1. Undefined: no counter; a stalled owner holds the datapath indefinitely.

Test Plan:
- Ch0 req and samples 5,20,3(last) back-to-back -> rf_go with 5, rf_finish with 3, RESULT_LAT later result=17, result_ch=0, result_err=0, 1-cycle result_valid.
- Ch0 and ch1 request in the same cycle from reset -> ch0 granted first, ch1 next. Then both request again -> ch1 granted first (round-robin).
- Ch1 samples 100,gap,gap,40(last) -> rf_data_in holds 100 across gaps, result=60.
- Single-sample burst 7 with last -> rf_go=rf_finish=1 in the same cycle, result=0.
- Ch0 drops ch_req after samples 9,2 -> rf_finish is forced, result=7, result_err=1. With the macro, 255 gap cycles also yield result_err=1.
- Reset asserted mid-STREAM -> next cycle all outputs are at reset values, no result_valid, ptr=ch0.
